// File: rtl/universal_shift_register.sv
// Universal shift register (hold / shift right / shift left / parallel load) with a word counter.
// Optional rotate mode is compiled in when USR_ROTATE_EN is defined.
module universal_shift_register #(
  parameter int               WIDTH       = 8,
  parameter logic [WIDTH-1:0] RESET_VALUE = {WIDTH{1'b0}},
  localparam int              CW          = $clog2(WIDTH + 1)
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             en,
  input  logic [1:0]       mode,
  input  logic             sin_r,
  input  logic             sin_l,
  input  logic             rot,
  input  logic [WIDTH-1:0] d,
  output logic [WIDTH-1:0] q,
  output logic             sout_r,
  output logic             sout_l,
  output logic [CW-1:0]    cnt,
  output logic             word_done
);

  localparam logic [1:0] MODE_HOLD  = 2'b00;
  localparam logic [1:0] MODE_RIGHT = 2'b01;
  localparam logic [1:0] MODE_LEFT  = 2'b10;
  localparam logic [1:0] MODE_LOAD  = 2'b11;

  logic [WIDTH-1:0] shift_q, shift_d;
  logic [CW-1:0]    cnt_q, cnt_d;
  logic             word_done_q, word_done_d;
  logic             in_r, in_l;
  logic             is_shift;

`ifdef USR_ROTATE_EN
  // Rotating feeds the bit falling off the far end back into the vacated position.
  assign in_r = rot ? shift_q[0]       : sin_r;
  assign in_l = rot ? shift_q[WIDTH-1] : sin_l;
`else
  logic unused_rot;
  assign unused_rot = rot;
  assign in_r       = sin_r;
  assign in_l       = sin_l;
`endif

  assign is_shift = en && ((mode == MODE_RIGHT) || (mode == MODE_LEFT));

  always_comb begin
    shift_d     = shift_q;
    cnt_d       = cnt_q;
    word_done_d = 1'b0;
    if (en) begin
      case (mode)
        MODE_HOLD:  shift_d = shift_q;
        MODE_RIGHT: shift_d = {in_r, shift_q[WIDTH-1:1]};
        MODE_LEFT:  shift_d = {shift_q[WIDTH-2:0], in_l};
        MODE_LOAD: begin
          shift_d = d;
          cnt_d   = '0;
        end
        default:    shift_d = shift_q;
      endcase
    end
    // Both directions advance the same counter; the WIDTH-th shift wraps it and pulses word_done.
    if (is_shift) begin
      if (cnt_q == CW'(WIDTH - 1)) begin
        cnt_d       = '0;
        word_done_d = 1'b1;
      end else begin
        cnt_d = cnt_q + CW'(1);
      end
    end
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      shift_q     <= RESET_VALUE;
      cnt_q       <= '0;
      word_done_q <= 1'b0;
    end else begin
      shift_q     <= shift_d;
      cnt_q       <= cnt_d;
      word_done_q <= word_done_d;
    end
  end

  assign q         = shift_q;
  assign cnt       = cnt_q;
  assign word_done = word_done_q;
  assign sout_r    = shift_q[0];
  assign sout_l    = shift_q[WIDTH-1];

endmodule

// File: doc/universal_shift_register.md
Name: universal_shift_register

Overview:
- Parametrised universal shift register: hold, shift right, shift left and parallel load on a single register.
- Carries a shift counter that flags each completed WIDTH-bit word, for use as a serializer/deserializer front end.
- Successor to the team's fixed 4-bit SISO right-shifter. Sits between serial links and parallel datapaths.

Parameters:
WIDTH, 8, register width in bits; legal range is 2 or more.
RESET_VALUE, {WIDTH{1'b0}}, value loaded into q on reset.

Ports:
clk  input  1  clock; all state updates on the rising edge.
reset  input  1  asynchronous, active-high reset.
en  input  1  clock enable; when 0, all state is frozen.
mode  input  2  operation: 00 hold, 01 shift right, 10 shift left, 11 parallel load.
sin_r  input  1  serial input; enters q[WIDTH-1] on a right shift.
sin_l  input  1  serial input; enters q[0] on a left shift.
rot  input  1  rotate select; functional only with the optional feature.
d  input  WIDTH  parallel load data.
q  output  WIDTH  register contents.
sout_r  output  1  right-shift serial output, equal to q[0] (combinational from q).
sout_l  output  1  left-shift serial output, equal to q[WIDTH-1] (combinational from q).
cnt  output  CW  shifts since the last load or wrap; CW = $clog2(WIDTH+1).
word_done  output  1  one-cycle pulse marking the WIDTH-th shift.

Behaviour:
- Reset (asynchronous, active-high): q = RESET_VALUE, cnt = 0, word_done = 0. Reset takes effect immediately, including mid-word. After release, the first shift counts as shift 1.
- en = 0: q and cnt hold; word_done = 0 on the next edge.
- en = 1, mode 00 (hold): q and cnt unchanged; word_done = 0.
- en = 1, mode 01 (shift right): q <= {sin_r, q[WIDTH-1:1]}.
- en = 1, mode 10 (shift left): q <= {q[WIDTH-2:0], sin_l}.
- en = 1, mode 11 (load): q <= d; cnt <= 0; word_done <= 0.
- Counter on each shift (mode 01 or 10 with en = 1):
  - if cnt == WIDTH-1: cnt <= 0 and word_done <= 1;
  - otherwise cnt <= cnt+1 and word_done <= 0.
- word_done timing:
  - Registered; high for exactly the one cycle following the edge that performed the WIDTH-th shift.
  - Back-to-back words give a pulse every WIDTH shift cycles.
- Mixed directions: left and right shifts both advance the same counter; direction is not tracked.
- cnt never exceeds WIDTH-1.
- Load wins over any pending count. A load on the cycle that would have completed a word produces no word_done.
- Latency: q, cnt and word_done reflect an operation one clock after the sampling edge.
- sout_r and sout_l are combinational from q; no additional latency.
- Without the optional feature, rot is ignored.

Optional Feature:
Macro: USR_ROTATE_EN.
- Defined, rot = 1: shifts become rotates and sin_r/sin_l are ignored.
  - mode 01: q <= {q[0], q[WIDTH-1:1]}.
  - mode 10: q <= {q[WIDTH-2:0], q[WIDTH-1]}.
  - Counter and word_done behave exactly as for ordinary shifts.
- Defined, rot = 0: behaviour is identical to the macro being undefined.
- Undefined: rot has no effect; no rotate logic is synthesised.

Test Plan:
1. WIDTH=4, assert reset mid-operation with q=4'b1011, cnt=2 -> q=0000, cnt=0, word_done=0 immediately, without waiting for a clock edge.
2. WIDTH=4: load d=4'b0000, then 4 right shifts with sin_r sequence 1,0,1,1 -> q=1101 after the 4th shift; cnt goes 1,2,3,0; word_done high for exactly the one cycle after the 4th shift.
3. WIDTH=4: load d=4'b1001, then left shifts with sin_l=0 -> q=0010, 0100, 1000, 0000; sout_l follows q[3]; word_done pulses after the 4th shift.
4. WIDTH=4: 3 shifts, then en=0 for 5 cycles, then 1 more shift -> q and cnt frozen during en=0; word_done pulses only after the 4th real shift.
5. WIDTH=4: 3 shifts, then load d=4'b0110 on the cycle the 4th shift would occur -> q=0110, cnt=0, no word_done pulse.
6. USR_ROTATE_EN defined, WIDTH=8: load 8'hA5, rot=1, 8 right shifts -> q visits 8'hD2 after the first shift and returns to 8'hA5 after the 8th, with word_done pulsing; with the macro undefined, the same stimulus shifts in sin_r.
